branch_ctrl: RTL and testbench

- Branch resolution controller for the pipelined core. It sequences the shared branch comparator: drives the unsigned-select input and turns the less/equal flags plus funct3 into a taken decision.
- Keeps a bimodal 2-bit branch history table (BHT) that fetch reads for prediction.
- Issues a registered redirect on mispredict and holds the pipeline flush for a programmable number of cycles.

---
 rtl/branch_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution, bimodal BHT prediction and mispredict redirect/flush sequencing.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  input  logic        i_valid,
  input  logic        i_is_jump,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_target,
  input  logic        i_ex_pred_taken,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_taken,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             idle, illegal, cond_taken, taken, mispred, upd;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_fetch_bits;

  assign unused_fetch_bits = ^{i_fetch_pc[31:IDX_W+2], i_fetch_pc[1:0]};

  // funct3 bit 1 selects unsigned compare for BLTU/BGEU; bit 0 inverts the base condition
  assign o_br_un    = i_funct3[1];
  assign illegal    = ~i_is_jump & (i_funct3[2:1] == 2'b01);
  assign cond_taken = i_funct3[2] ? (i_br_less ^ i_funct3[0])
                                  : (~i_funct3[1] & (i_br_equal ^ i_funct3[0]));
  assign taken      = i_is_jump | cond_taken;
  assign o_taken    = i_valid & taken;
  assign idle       = state_q == S_IDLE;
  assign mispred    = i_valid & idle & ~illegal & (taken != i_ex_pred_taken);
  assign upd        = i_valid & idle & ~i_is_jump & ~illegal;
  assign ex_idx     = i_pc[IDX_W+1:2];

  // fetch sees the stored counter, so a same-cycle update is not forwarded
  assign o_pred_taken = bht_q[i_fetch_pc[IDX_W+1:2]][1];

  // saturating 2-bit counter update for the resolving branch
  always_comb begin
    bht_d = bht_q;
    if (upd) bht_d[ex_idx] = taken ? (bht_q[ex_idx] == 2'b11 ? 2'b11 : bht_q[ex_idx] + 2'b01)
                                   : (bht_q[ex_idx] == 2'b00 ? 2'b00 : bht_q[ex_idx] - 2'b01);
  end

  // BHT storage, reset to weakly not-taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  // mispredict enters FLUSH; the counter runs down to zero before returning to IDLE
  always_comb begin
    state_d       = idle ? (mispred ? S_FLUSH : S_IDLE) : (cnt_q == 4'd0 ? S_IDLE : S_FLUSH);
    cnt_d         = idle ? 4'(FLUSH_CYCLES - 1) : cnt_q - 4'd1;
    redirect_d    = mispred;
    redirect_pc_d = mispred ? (taken ? i_target : i_pc + 32'd4) : redirect_pc_q;
  end

  // FSM and redirect registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_flush       = state_q == S_FLUSH;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  // count resolved branches/jumps and mispredicts seen in IDLE
  always_comb begin
    br_cnt_d  = (i_valid & idle & ~illegal) ? br_cnt_q + 32'd1 : br_cnt_q;
    mis_cnt_d = mispred ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end

  // statistics registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mis_cnt_q;
`else
  assign o_br_count      = 32'd0;
  assign o_mispred_count = 32'd0;
`endif
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed stimulus with a redirect scoreboard checked by an independent monitor.
module tb_branch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = 32'd0;
  logic        pred_taken;
  logic        valid = 1'b0, is_jump = 1'b0, ex_pred = 1'b0, br_less = 1'b0, br_equal = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] pc = 32'd0, target = 32'd0;
  logic        br_un, taken, redirect, flush;
  logic [31:0] redirect_pc, br_count, mispred_count;
  int          tests = 0, fails = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  branch_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc), .o_pred_taken(pred_taken),
    .i_valid(valid), .i_is_jump(is_jump), .i_funct3(funct3), .i_pc(pc), .i_target(target),
    .i_ex_pred_taken(ex_pred), .o_br_un(br_un), .i_br_less(br_less), .i_br_equal(br_equal),
    .o_taken(taken), .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_flush(flush),
    .o_br_count(br_count), .o_mispred_count(mispred_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every redirect pulse must match the oldest expected target
  always @(negedge clk) begin
    if (rst_n && redirect) begin
      if (exp_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
      else chk("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  // one EX-stage instruction; returns #1 after the edge that samples it
  task automatic br(input logic j, input logic [2:0] f3, input logic [31:0] ipc, tgt,
                    input logic pt, lt, eq, et, er, input logic [31:0] epc);
    @(negedge clk);
    valid = 1'b1; is_jump = j; funct3 = f3; pc = ipc; target = tgt;
    ex_pred = pt; br_less = lt; br_equal = eq;
    #1;
    chk("o_taken", {31'd0, taken}, {31'd0, et});
    chk("o_br_un", {31'd0, br_un}, {31'd0, f3[1]});
    if (er) exp_q.push_back(epc);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic pred(input logic [31:0] a, input logic e, input string name);
    fetch_pc = a; #1;
    chk(name, {31'd0, pred_taken}, {31'd0, e});
  endtask

  task automatic fl(input logic e);
    @(posedge clk); #1;
    chk("o_flush", {31'd0, flush}, {31'd0, e});
  endtask

  initial begin
    #2;
    for (int i = 0; i < 16; i++) pred(i << 2, 1'b0, "reset_pred");
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    // BLTU taken, predicted not-taken
    br(0, 3'b110, 32'h100, 32'h80, 0, 1, 0, 1, 1, 32'h80);
    chk("redirect_pulse", {31'd0, redirect}, 32'd1);
    chk("o_flush", {31'd0, flush}, 32'd1);
    fl(1); fl(0);
    pred(32'h100, 1'b1, "pred_after_bltu");
    // BNE not taken, predicted taken, PC wraps
    br(0, 3'b001, 32'hFFFF_FFFC, 32'h40, 1, 0, 1, 0, 1, 32'h0);
    fl(1); fl(0);
    // mispredict followed by a branch during FLUSH
    br(0, 3'b000, 32'h10, 32'h200, 0, 0, 1, 1, 1, 32'h200);
    br(0, 3'b000, 32'h14, 32'h300, 0, 0, 1, 1, 0, 32'h0);
    chk("o_flush_2nd", {31'd0, flush}, 32'd1);
    fl(0);
    pred(32'h14, 1'b0, "pred_ignored_in_flush");
    pred(32'h10, 1'b1, "pred_first_branch");
    // saturation on index 8, back-to-back
    br(0, 3'b101, 32'h20, 32'h0, 1, 0, 0, 1, 0, 32'h0);
    br(0, 3'b101, 32'h20, 32'h0, 1, 0, 0, 1, 0, 32'h0);
    br(0, 3'b101, 32'h20, 32'h0, 1, 0, 0, 1, 0, 32'h0);
    pred(32'h20, 1'b1, "pred_sat_11");
    br(0, 3'b101, 32'h20, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    pred(32'h20, 1'b1, "pred_sat_10");
    br(0, 3'b101, 32'h20, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    pred(32'h20, 1'b0, "pred_sat_01");
    chk("no_flush_correct", {31'd0, flush}, 32'd0);
    // illegal funct3 on an index holding 10
    br(0, 3'b010, 32'h100, 32'h500, 1, 1, 1, 0, 0, 32'h0);
    br(0, 3'b011, 32'h100, 32'h500, 1, 1, 1, 0, 0, 32'h0);
    chk("illegal_no_flush", {31'd0, flush}, 32'd0);
    pred(32'h100, 1'b1, "pred_illegal_unchanged");
    // JAL predicted not-taken: redirect, no BHT update
    br(1, 3'b000, 32'h14, 32'h440, 0, 0, 0, 1, 1, 32'h440);
    fl(1); fl(0);
    pred(32'h14, 1'b0, "pred_jump_no_update");
`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, 32'd9);
    chk("mispred_count", mispred_count, 32'd4);
`else
    chk("br_count", br_count, 32'd0);
    chk("mispred_count", mispred_count, 32'd0);
`endif
    // reset mid-flush aborts immediately
    br(0, 3'b000, 32'h30, 32'h600, 0, 0, 1, 1, 1, 32'h600);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("reset_abort_flush", {31'd0, flush}, 32'd0);
    chk("reset_abort_redirect", {31'd0, redirect}, 32'd0);
    pred(32'h100, 1'b0, "pred_after_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pending_redirects", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
